// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data-memory port between the CPU MEM stage and an EXT loader/DMA master
module dmem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [3:0]        ext_len,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              burst_active,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {
        IDLE      = 1'b0,
        EXT_BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          starve_q, starve_d;
    logic [3:0]          beats_q, beats_d;
    logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
    logic                ext_rvalid_q, ext_rvalid_d;
    logic                cpu_gnt;
    logic                ext_gnt_c;

    // Grant decision and next-state; no grant is issued while reset is held low.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        beats_d   = beats_q;
        cpu_gnt   = 1'b0;
        ext_gnt_c = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (ext_req && (starve_q == STARVE_LIM)) begin
                        ext_gnt_c = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                        if (ext_req && (starve_q < STARVE_LIM)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else if (ext_req) begin
                        ext_gnt_c = 1'b1;
                    end
                    if (ext_gnt_c) begin
                        starve_d = 4'd0;
                        beats_d  = ext_len;
                        if (ext_len != 4'd0) begin
                            state_d = EXT_BURST;
                        end
                    end
                end
                EXT_BURST: begin
                    if (ext_req) begin
                        ext_gnt_c = 1'b1;
                        if (beats_q <= 4'd1) begin
                            beats_d = 4'd0;
                            state_d = IDLE;
                        end else begin
                            beats_d = beats_q - 4'd1;
                        end
                    end else begin
                        // Master walked away mid-burst: drop the rest of it.
                        beats_d = 4'd0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Memory port mux and EXT read-response capture.
    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        ext_rvalid_d = 1'b0;
        ext_rdata_d  = ext_rdata_q;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            mem_re    = ~cpu_we;
        end else if (ext_gnt_c) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_we    = ext_we;
            mem_re    = ~ext_we;
            if (!ext_we) begin
                ext_rvalid_d = 1'b1;
                ext_rdata_d  = mem_rdata;
            end
        end
    end

    // State, counters and registered EXT read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_q     <= 4'd0;
            beats_q      <= 4'd0;
            ext_rdata_q  <= '0;
            ext_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            beats_q      <= beats_d;
            ext_rdata_q  <= ext_rdata_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

    assign cpu_rdata    = mem_rdata;
    assign cpu_stall    = cpu_req & ~cpu_gnt;
    assign ext_gnt      = ext_gnt_c;
    assign ext_rdata    = ext_rdata_q;
    assign ext_rvalid   = ext_rvalid_q;
    assign burst_active = (state_q == EXT_BURST);

endmodule
